// File: rtl/lca_adder16.sv
// lca_adder16: 16-bit two-level carry-lookahead adder with a registered result.
// Four 4-bit lookahead groups feed a second-level unit that forms the group
// carries directly from cin, so no carry ripples between bits or between groups.
// Block propagate/generate are exported so wider adders can be cascaded.
// Optional build macro LCA_INREG_EN adds an input register stage in front of the
// lookahead logic (latency 2 instead of 1, throughput unchanged).
module lca_adder16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic        out_valid,
    output logic [15:0] sum,
    output logic        cout,
    output logic        p_out,
    output logic        g_out
);

    localparam int unsigned WIDTH = 16;
    localparam int unsigned GRP_W = 4;

    // Group propagate/generate: returns {P, G} for one 4-bit group.
    function automatic logic [1:0] grp_pg(input logic [GRP_W-1:0] p,
                                          input logic [GRP_W-1:0] g);
        logic grp_p;
        logic grp_g;
        grp_p = p[3] & p[2] & p[1] & p[0];
        grp_g = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        return {grp_p, grp_g};
    endfunction

    // Bit carries inside one group, fully expanded from the group carry-in.
    // Bit 0 of the result is the group carry-in itself.
    function automatic logic [GRP_W-1:0] grp_carry(input logic [GRP_W-1:0] p,
                                                   input logic [GRP_W-1:0] g,
                                                   input logic             ci);
        logic [GRP_W-1:0] c;
        c[0] = ci;
        c[1] = g[0]
             | (p[0] & ci);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & ci);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Operands as seen by the lookahead logic
    logic             op_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;

`ifdef LCA_INREG_EN
    // Input stage: register operands every cycle, valid travels alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
        end else begin
            op_valid <= in_valid;
            op_a     <= a;
            op_b     <= b;
            op_cin   <= cin;
        end
    end
`else
    // No input stage: lookahead logic works straight off the ports
    always_comb begin
        op_valid = in_valid;
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
    end
`endif

    // Bit-level propagate and generate
    logic [WIDTH-1:0] bit_p;
    logic [WIDTH-1:0] bit_g;

    // Half-sum and carry-generate per bit
    always_comb begin
        bit_p = op_a ^ op_b;
        bit_g = op_a & op_b;
    end

    // Group-level propagate and generate
    logic [3:0] grp_p;
    logic [3:0] grp_g;

    // Reduce each 4-bit slice to its group P/G
    always_comb begin
        {grp_p[0], grp_g[0]} = grp_pg(bit_p[3:0],   bit_g[3:0]);
        {grp_p[1], grp_g[1]} = grp_pg(bit_p[7:4],   bit_g[7:4]);
        {grp_p[2], grp_g[2]} = grp_pg(bit_p[11:8],  bit_g[11:8]);
        {grp_p[3], grp_g[3]} = grp_pg(bit_p[15:12], bit_g[15:12]);
    end

    // Second-level carries: grp_c[k] is the carry into group k, grp_c[4] is c16
    logic [4:0] grp_c;
    logic       blk_p;
    logic       blk_g;

    // Second-level lookahead, every group carry expanded directly from cin
    always_comb begin
        grp_c[0] = op_cin;
        grp_c[1] = grp_g[0]
                 | (grp_p[0] & op_cin);
        grp_c[2] = grp_g[1]
                 | (grp_p[1] & grp_g[0])
                 | (grp_p[1] & grp_p[0] & op_cin);
        grp_c[3] = grp_g[2]
                 | (grp_p[2] & grp_g[1])
                 | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & op_cin);
        grp_c[4] = grp_g[3]
                 | (grp_p[3] & grp_g[2])
                 | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & op_cin);
        blk_g    = grp_g[3]
                 | (grp_p[3] & grp_g[2])
                 | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
        blk_p    = grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0];
    end

    // Bit carries and sum
    logic [WIDTH-1:0] bit_c;
    logic [WIDTH-1:0] sum_c;

    // Expand bit carries inside each group from its group carry-in
    always_comb begin
        bit_c[3:0]   = grp_carry(bit_p[3:0],   bit_g[3:0],   grp_c[0]);
        bit_c[7:4]   = grp_carry(bit_p[7:4],   bit_g[7:4],   grp_c[1]);
        bit_c[11:8]  = grp_carry(bit_p[11:8],  bit_g[11:8],  grp_c[2]);
        bit_c[15:12] = grp_carry(bit_p[15:12], bit_g[15:12], grp_c[3]);
        sum_c        = bit_p ^ bit_c;
    end

    // Output register: capture on valid, hold otherwise; valid follows one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            p_out     <= 1'b0;
            g_out     <= 1'b0;
        end else begin
            out_valid <= op_valid;
            if (op_valid) begin
                sum   <= sum_c;
                cout  <= grp_c[4];
                p_out <= blk_p;
                g_out <= blk_g;
            end
        end
    end

endmodule

// File: tb/tb_lca_adder16.sv
// Testbench for lca_adder16: arithmetic reference model plus literal expectations.
module tb_lca_adder16;

`ifdef LCA_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;
    logic        p_out;
    logic        g_out;

    lca_adder16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .p_out     (p_out),
        .g_out     (g_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {cout, p_out, g_out, sum} from plain arithmetic
    function automatic logic [18:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
        logic [16:0] t;
        logic [16:0] t0;
        t  = 17'(x) + 17'(y) + 17'(ci);
        t0 = 17'(x) + 17'(y);
        return {t[16], ((x ^ y) == 16'hFFFF), t0[16], t[15:0]};
    endfunction

    // Operation reaching the output register at the next rising edge
    logic        m_v;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic        m_cin;

`ifdef LCA_INREG_EN
    logic        d1_v;
    logic [15:0] d1_a;
    logic [15:0] d1_b;
    logic        d1_cin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_v <= 1'b0; d1_a <= '0; d1_b <= '0; d1_cin <= 1'b0;
        end else begin
            d1_v <= in_valid; d1_a <= a; d1_b <= b; d1_cin <= cin;
        end
    end

    always_comb begin
        m_v = d1_v; m_a = d1_a; m_b = d1_b; m_cin = d1_cin;
    end
`else
    always_comb begin
        m_v = in_valid; m_a = a; m_b = b; m_cin = cin;
    end
`endif

    // Expected outputs
    logic        exp_v;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_p;
    logic        exp_g;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_v <= 1'b0; exp_sum <= '0; exp_cout <= 1'b0; exp_p <= 1'b0; exp_g <= 1'b0;
        end else begin
            exp_v <= m_v;
            if (m_v) {exp_cout, exp_p, exp_g, exp_sum} <= ref_add(m_a, m_b, m_cin);
        end
    end

    // Literal expectations set by the stimulus process
    logic        chk_en;
    logic        chk_pulse;
    logic        lit_on;
    string       lit_name;
    logic        lit_v;
    logic [15:0] lit_sum;
    logic        lit_cout;
    logic        lit_p;
    logic        lit_g;

    int checks;
    int errors;

    // Compare process: model every negedge, literals when armed, extra pulses mid-reset
    always @(negedge clk or posedge chk_pulse) begin
        if (chk_en) begin
            checks = checks + 1;
            if ({out_valid, cout, p_out, g_out, sum} !== {exp_v, exp_cout, exp_p, exp_g, exp_sum}) begin
                errors = errors + 1;
                $display("FAIL model t=%0t got v=%b sum=%h cout=%b p=%b g=%b want v=%b sum=%h cout=%b p=%b g=%b",
                         $time, out_valid, sum, cout, p_out, g_out, exp_v, exp_sum, exp_cout, exp_p, exp_g);
            end
            if (lit_on) begin
                checks = checks + 1;
                if ({out_valid, cout, p_out, g_out, sum} !== {lit_v, lit_cout, lit_p, lit_g, lit_sum}) begin
                    errors = errors + 1;
                    $display("FAIL %s t=%0t got v=%b sum=%h cout=%b p=%b g=%b want v=%b sum=%h cout=%b p=%b g=%b",
                             lit_name, $time, out_valid, sum, cout, p_out, g_out,
                             lit_v, lit_sum, lit_cout, lit_p, lit_g);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic c);
        @(negedge clk);
        #1;
        in_valid = v; a = x; b = y; cin = c;
    endtask

    task automatic set_lit(input string nm, input logic v, input logic [15:0] s,
                           input logic co, input logic p, input logic g);
        lit_name = nm; lit_v = v; lit_sum = s; lit_cout = co; lit_p = p; lit_g = g;
        lit_on = 1'b1;
    endtask

    task automatic pulse_check();
        chk_pulse = 1'b1;
        #1;
        chk_pulse = 1'b0;
    endtask

    // One operation, then check the held result against hand-computed values
    task automatic run_lit(input string nm, input logic [15:0] x, input logic [15:0] y,
                           input logic c, input logic [15:0] s, input logic co,
                           input logic p, input logic g);
        drive(1'b1, x, y, c);
        repeat (LAT) drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        set_lit(nm, 1'b0, s, co, p, g);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        lit_on = 1'b0;
    endtask

    initial begin
        logic        v;
        logic [15:0] x;
        logic [15:0] y;
        logic        c;
        int unsigned sel;

        checks = 0; errors = 0;
        chk_en = 1'b0; chk_pulse = 1'b0; lit_on = 1'b0;
        lit_name = "none"; lit_v = 1'b0; lit_sum = '0; lit_cout = 1'b0; lit_p = 1'b0; lit_g = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Power-on reset state
        #2;
        chk_en = 1'b1;
        set_lit("reset_state", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        pulse_check();
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        rst_n = 1'b1;
        set_lit("idle_after_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        lit_on = 1'b0;

        // Directed vectors with hand-computed results
        run_lit("a90af_c0", 16'h90AF, 16'h6FAF, 1'b0, 16'h005E, 1'b1, 1'b0, 1'b1);
        run_lit("a90af_c1", 16'h90AF, 16'h6FAF, 1'b1, 16'h005F, 1'b1, 1'b0, 1'b1);
        run_lit("aaf90_c0", 16'hAF90, 16'hAF6F, 1'b0, 16'h5EFF, 1'b1, 1'b0, 1'b1);
        run_lit("aaf90_c1", 16'hAF90, 16'hAF6F, 1'b1, 16'h5F00, 1'b1, 1'b0, 1'b1);
        run_lit("small_c0", 16'h0002, 16'h0006, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
        run_lit("small_c1", 16'h0002, 16'h0006, 1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
        run_lit("allprop_c0", 16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        run_lit("allprop_c1", 16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_lit("ffff_plus1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_lit("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_lit("allprop_hold", 16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-operation with a nonzero result held
        drive(1'b1, 16'h1234, 16'h1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        set_lit("async_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        pulse_check();
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b1);
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
        rst_n = 1'b1;
        set_lit("hold_after_release", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 16'hBEEF, 16'hCAFE, 1'b1);
        lit_on = 1'b0;

        // Randomized traffic with gaps and occasional full-propagate pairs
        for (int i = 0; i < 12000; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 15);
            x   = 16'($urandom);
            y   = 16'($urandom);
            c   = 1'($urandom_range(0, 1));
            if (sel == 0) begin
                y = ~x;
                c = 1'b1;
            end else if (sel == 1) begin
                x = 16'hFFFF;
            end
            drive(v, x, y, c);
        end
        repeat (LAT + 2) drive(1'b0, 16'h0000, 16'h0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
